// File: rtl/pipeline_stage_skid.sv
// Elastic pipeline stage: valid/ready handshake, 2-entry skid buffer,
// synchronous flush, NOP fill on bubbles and a saturating stall counter.
module pipeline_stage_skid #(
  parameter int                DATA_W  = 96,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'({32'h00000013, 64'h0}),
  parameter bit                SKID_EN = 1'b1,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_fire, out_fire;

  assign out_valid   = (state_q != EMPTY);
  assign out_data    = main_q;
  assign in_ready    = SKID_EN ? rdy_q : (out_ready | ~out_valid);
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign stall_count = cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire && SKID_EN) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
          main_d  = NOP_VAL;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = NOP_VAL;
      end
    endcase
    // flush wins over any handshake in the same cycle
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VAL;
    end
  end

  always_comb begin
    rdy_d = (state_d != TWO);
    cnt_d = cnt_q;
    if (out_valid && !out_ready && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: queue model for the default stage,
// directed checks for the CNT_W=4 and SKID_EN=0 variants.
module tb_pipeline_stage_skid;

  localparam logic [95:0] NOP = {32'h00000013, 64'h0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // default instance
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [95:0] a_in_data, a_out_data;
  logic [15:0] a_stall;

  // CNT_W = 4 instance
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [95:0] b_in_data, b_out_data;
  logic [3:0]  b_stall;

  // SKID_EN = 0 instance
  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [95:0] c_in_data, c_out_data;
  logic [15:0] c_stall;

  pipeline_stage_skid u_a (
    .clk(clk), .reset(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stall_count(a_stall)
  );

  pipeline_stage_skid #(.CNT_W(4)) u_b (
    .clk(clk), .reset(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall_count(b_stall)
  );

  pipeline_stage_skid #(.SKID_EN(1'b0)) u_c (
    .clk(clk), .reset(rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .stall_count(c_stall)
  );

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // queue model of the default stage: up to two held words, FIFO order
  logic [95:0] mq[$];
  logic        m_rdy;
  logic [15:0] m_cnt;

  always @(posedge clk or posedge rst) begin
    bit inf, outf;
    if (rst) begin
      mq.delete();
      m_rdy = 1'b1;
      m_cnt = 16'd0;
    end else begin
      inf  = a_in_valid && m_rdy;
      outf = (mq.size() > 0) && a_out_ready;
      if (mq.size() > 0 && !a_out_ready && m_cnt != 16'hffff) m_cnt++;
      if (a_flush) begin
        mq.delete();
      end else begin
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back(a_in_data);
      end
      m_rdy = (mq.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", 96'(a_out_valid), 96'(mq.size() > 0));
      chk("m_out_data", a_out_data, (mq.size() > 0) ? mq[0] : NOP);
      chk("m_in_ready", 96'(a_in_ready), 96'(m_rdy));
      chk("m_stall", 96'(a_stall), 96'(m_cnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_flush = 0; c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
    repeat (2) cyc();
    chk("rst_valid", 96'(a_out_valid), 96'd0);
    chk("rst_ready", 96'(a_in_ready), 96'd1);
    chk("rst_data", a_out_data, NOP);
    chk("rst_stall", 96'(a_stall), 96'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // stream 1..8 with out_ready held high
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1;
      a_in_data = 96'(i);
      cyc();
      chk("stream_data", a_out_data, 96'(i));
      chk("stream_ready", 96'(a_in_ready), 96'd1);
    end
    a_in_valid = 0;
    cyc();
    chk("stream_end_valid", 96'(a_out_valid), 96'd0);
    chk("stream_end_data", a_out_data, NOP);

    // backpressure: A at output, B in skid, C waits
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 96'hA;
    cyc();
    chk("bp_a", a_out_data, 96'hA);
    chk("bp_rdy1", 96'(a_in_ready), 96'd1);
    a_in_data = 96'hB;
    cyc();
    chk("bp_hold_a", a_out_data, 96'hA);
    chk("bp_rdy0", 96'(a_in_ready), 96'd0);
    a_in_data = 96'hC;
    cyc();
    chk("bp_stable", a_out_data, 96'hA);
    chk("bp_stall", 96'(a_stall), 96'd2);
    a_out_ready = 1;
    cyc();
    chk("bp_b", a_out_data, 96'hB);
    cyc();
    chk("bp_c", a_out_data, 96'hC);
    a_in_valid = 0;
    cyc();
    chk("bp_empty", 96'(a_out_valid), 96'd0);
    chk("bp_nop", a_out_data, NOP);

    // flush while two entries are held, with an offer in the same cycle
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 96'hD;
    cyc();
    a_in_data = 96'hE;
    cyc();
    chk("fl_full", 96'(a_in_ready), 96'd0);
    a_flush = 1; a_in_data = 96'hF;
    cyc();
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    chk("fl_valid", 96'(a_out_valid), 96'd0);
    chk("fl_data", a_out_data, NOP);
    chk("fl_ready", 96'(a_in_ready), 96'd1);
    chk("fl_stall", 96'(a_stall), 96'd4);
    cyc();
    chk("fl_gone", 96'(a_out_valid), 96'd0);

    // async reset pulse between edges while two entries are held
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 96'h51;
    cyc();
    a_in_data = 96'h52;
    cyc();
    a_in_valid = 0;
    chk("ar_full", 96'(a_in_ready), 96'd0);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid", 96'(a_out_valid), 96'd0);
    chk("ar_ready", 96'(a_in_ready), 96'd1);
    chk("ar_data", a_out_data, NOP);
    chk("ar_stall", 96'(a_stall), 96'd0);
    #1 rst = 1'b0;
    a_out_ready = 1;
    cyc();

    // stall counter saturation at CNT_W=4
    b_in_valid = 1; b_in_data = 96'h55;
    cyc();
    b_in_valid = 0;
    repeat (20) cyc();
    chk("sat_cnt", 96'(b_stall), 96'd15);
    chk("sat_data", b_out_data, 96'h55);
    b_flush = 1;
    cyc();
    b_flush = 0;
    chk("sat_flush_cnt", 96'(b_stall), 96'd15);
    chk("sat_flush_valid", 96'(b_out_valid), 96'd0);

    // single-entry mode: in_ready follows out_ready combinationally
    c_in_valid = 1; c_in_data = 96'h66;
    cyc();
    c_in_data = 96'h77;
    chk("s0_load", c_out_data, 96'h66);
    chk("s0_rdy_lo", 96'(c_in_ready), 96'd0);
    c_out_ready = 1;
    #1;
    chk("s0_rdy_hi", 96'(c_in_ready), 96'd1);
    cyc();
    chk("s0_next", c_out_data, 96'h77);
    c_out_ready = 0;
    #1;
    chk("s0_rdy_lo2", 96'(c_in_ready), 96'd0);
    c_in_data = 96'h88;
    cyc();
    chk("s0_hold", c_out_data, 96'h77);
    c_in_valid = 0; c_out_ready = 1;
    cyc();
    chk("s0_empty", 96'(c_out_valid), 96'd0);
    chk("s0_nop", c_out_data, NOP);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
